// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: branch redirect, imem req/ack, decode valid/ready.
// master = fetch unit side, slave = environment (branch ctl, imem, decode).
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               redirect_valid;
  logic [31:0]        redirect_target;
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [31:0]        pc_out;

  modport master (
    input  redirect_valid, redirect_target, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr_out, pc_out
  );

  modport slave (
    output redirect_valid, redirect_target, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr_out, pc_out
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC mux: aligned redirect target > sequential step after a fetch > hold.
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        advance,
  input  logic [31:0] cur_addr,
  input  logic [31:0] pc,
  output logic [31:0] pc_nxt
);

  // redirect always wins; the step wraps modulo 2^32
  always_comb begin
    pc_nxt = pc;
    if (redirect_valid)
      pc_nxt = redirect_target & ALIGN_MASK;
    else if (advance)
      pc_nxt = cur_addr + PC_STEP;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and fetch sequencer: issues word-aligned imem reads and hands
// fetched words to decode. Optional ack watchdog under FETCH_TIMEOUT_EN
// (adds the fetch_err port).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_fetch_unit_if.master     bus
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                   fetch_err
`endif
);

  state_t             state, state_nxt;
  logic [31:0]        pc, pc_nxt;
  logic               squash, squash_nxt;
  logic               req_nxt, valid_nxt;
  logic [31:0]        addr_nxt, pcout_nxt;
  logic [INSTR_W-1:0] iout_nxt;
  logic               advance;
  logic               halted;
  logic               to_hit;

  // sequential step only when an unsquashed fetch completes
  assign advance = (state == S_FETCH) && bus.imem_ack && !bus.redirect_valid;

  pc_next_sel u_pc_sel (
    .redirect_valid (bus.redirect_valid),
    .redirect_target(bus.redirect_target),
    .advance        (advance),
    .cur_addr       (bus.imem_addr),
    .pc             (pc),
    .pc_nxt         (pc_nxt)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        waiting;

  assign waiting = (state == S_FETCH) || (state == S_FLUSH);
  assign to_hit  = waiting && !bus.imem_ack && (to_cnt == 32'(TIMEOUT_CYC - 1));
  assign halted  = fetch_err;

  // watchdog: restarts on entering a wait state, counts ack-less cycles there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (!waiting || state_nxt != state) to_cnt <= '0;
      else                                to_cnt <= to_cnt + 32'd1;
      if (to_hit) fetch_err <= 1'b1;
    end
  end
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = 32'(TIMEOUT_CYC);
  assign to_hit = 1'b0;
  assign halted = 1'b0;
`endif

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      pc              <= RESET_PC;
      squash          <= 1'b0;
      bus.imem_req    <= 1'b0;
      bus.imem_addr   <= RESET_PC;
      bus.instr_valid <= 1'b0;
      bus.instr_out   <= '0;
      bus.pc_out      <= '0;
    end else begin
      state           <= state_nxt;
      pc              <= pc_nxt;
      squash          <= squash_nxt;
      bus.imem_req    <= req_nxt;
      bus.imem_addr   <= addr_nxt;
      bus.instr_valid <= valid_nxt;
      bus.instr_out   <= iout_nxt;
      bus.pc_out      <= pcout_nxt;
    end
  end

  // next state / next outputs; redirect has priority, the watchdog overrides
  always_comb begin
    state_nxt  = state;
    squash_nxt = squash;
    req_nxt    = bus.imem_req;
    addr_nxt   = bus.imem_addr;
    valid_nxt  = bus.instr_valid;
    iout_nxt   = bus.instr_out;
    pcout_nxt  = bus.pc_out;
    case (state)
      S_IDLE: begin
        if (!halted) begin
          state_nxt = S_FETCH;
          req_nxt   = 1'b1;
          addr_nxt  = pc_nxt;
        end
      end
      S_FETCH: begin
        if (bus.redirect_valid) begin
          if (bus.imem_ack) begin
            // data arrived with the redirect: drop it and refetch
            state_nxt = S_IDLE;
            req_nxt   = 1'b0;
          end else begin
            // outstanding request must complete before refetching
            state_nxt  = S_FLUSH;
            squash_nxt = 1'b1;
          end
        end else if (bus.imem_ack && !squash) begin
          state_nxt = S_HOLD;
          req_nxt   = 1'b0;
          valid_nxt = 1'b1;
          iout_nxt  = bus.imem_rdata;
          pcout_nxt = bus.imem_addr;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          state_nxt = S_IDLE;
          valid_nxt = 1'b0;
        end else if (bus.instr_ready) begin
          state_nxt = S_FETCH;
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          addr_nxt  = pc_nxt;
        end
      end
      S_FLUSH: begin
        if (bus.imem_ack) begin
          state_nxt  = S_IDLE;
          req_nxt    = 1'b0;
          squash_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (to_hit) begin
      state_nxt  = S_IDLE;
      req_nxt    = 1'b0;
      squash_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetch addresses and
// delivered PCs are queued when stimulus is set up and popped on ack/transfer.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if ifc();
`ifdef FETCH_TIMEOUT_EN
  logic fetch_err;
`endif

  instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYC(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_err(fetch_err)
`endif
  );

  int total = 0;
  int bad   = 0;
  int budget = 0;
  int ack_dly = 1;
  bit dead_mode = 1'b0;
  int wcnt = 0;
  int req_run = 0;
  int last_run = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_pc[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // imem model: acks after ack_dly cycles while budget remains
  always @(negedge clk) begin
    if (!rst) begin
      ifc.imem_ack   = 1'b0;
      ifc.imem_rdata = '0;
      wcnt = 0; req_run = 0; prev_req = 1'b0;
    end else begin
      if (prev_req && ifc.imem_req) chk("addr_stable", ifc.imem_addr, prev_addr);
      prev_req  = ifc.imem_req;
      prev_addr = ifc.imem_addr;
      if (ifc.imem_req) req_run++;
      else if (req_run != 0) begin last_run = req_run; req_run = 0; end
      if (ifc.imem_ack) ifc.imem_ack = 1'b0;
      else if (ifc.imem_req && budget > 0) begin
        wcnt++;
        if (wcnt >= ack_dly) begin
          wcnt = 0;
          budget--;
          ifc.imem_ack   = 1'b1;
          ifc.imem_rdata = dead_mode ? 32'h0000_DEAD : mem_word(ifc.imem_addr);
          chk("addr_sb_nonempty", 32'(exp_addr.size() != 0), 32'd1);
          if (exp_addr.size() != 0) chk("imem_addr", ifc.imem_addr, exp_addr.pop_front());
        end
      end else wcnt = 0;
    end
  end

  // decode-side monitor: every accepted transfer must match the scoreboard
  always @(negedge clk) begin
    if (rst && ifc.instr_valid && ifc.instr_ready) begin
      chk("pc_sb_nonempty", 32'(exp_pc.size() != 0), 32'd1);
      if (exp_pc.size() != 0) begin
        logic [31:0] e;
        e = exp_pc.pop_front();
        chk("pc_out", ifc.pc_out, e);
        chk("instr_out", ifc.instr_out, mem_word(e));
      end
    end
  end

  task automatic pulse_redirect(input logic [31:0] tgt);
    ifc.redirect_valid  = 1'b1;
    ifc.redirect_target = tgt;
    @(posedge clk); #1;
    ifc.redirect_valid  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_pc.size() != 0; i++) @(negedge clk);
    chk(tag, exp_pc.size(), 0);
  endtask

  task automatic wait_budget(input string tag);
    for (int i = 0; i < 100 && budget != 0; i++) @(negedge clk);
    chk(tag, budget, 0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 100 && !ifc.instr_valid; i++) @(negedge clk);
    chk(tag, ifc.instr_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h_pc, h_in;
    ifc.redirect_valid  = 1'b0;
    ifc.redirect_target = '0;
    ifc.instr_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",   ifc.imem_req,    0);
    chk("rst_addr",  ifc.imem_addr,   32'h0);
    chk("rst_valid", ifc.instr_valid, 0);
    chk("rst_instr", ifc.instr_out,   0);
    chk("rst_pcout", ifc.pc_out,      0);

    // sequential fetch 0,4,8,C with single-cycle ack
    ifc.instr_ready = 1'b1;
    ack_dly = 1;
    for (int i = 0; i < 4; i++) begin
      exp_addr.push_back(32'(4 * i));
      exp_pc.push_back(32'(4 * i));
    end
    budget = 4;
    rst = 1'b1;
    drain("t1_drain");

    // decode stall: held instruction must not change, no new request
    @(posedge clk); #1;
    ifc.instr_ready = 1'b0;
    exp_addr.push_back(32'h10);
    budget = 1;
    wait_valid("t2_valid");
    h_pc = ifc.pc_out;
    h_in = ifc.instr_out;
    chk("t2_pc", h_pc, 32'h10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", ifc.instr_valid, 1);
      chk("t2_hold_pc",    ifc.pc_out,      h_pc);
      chk("t2_hold_instr", ifc.instr_out,   h_in);
      chk("t2_hold_noreq", ifc.imem_req,    0);
    end
    @(posedge clk); #1;
    exp_pc.push_back(32'h10);
    ifc.instr_ready = 1'b1;
    drain("t2_drain");

    // redirect during outstanding fetch: late DEAD data is squashed
    @(posedge clk); #1;
    exp_addr.push_back(32'h14);
    dead_mode = 1'b1;
    pulse_redirect(32'h100);
    @(negedge clk);
    chk("t3_flush_req",   ifc.imem_req,    1);
    chk("t3_flush_addr",  ifc.imem_addr,   32'h14);
    chk("t3_flush_valid", ifc.instr_valid, 0);
    @(posedge clk); #1;
    ack_dly = 3;
    budget = 1;
    wait_budget("t3_squash_ack");
    @(posedge clk); #1;
    dead_mode = 1'b0;
    ack_dly = 1;
    exp_addr.push_back(32'h100);
    exp_pc.push_back(32'h100);
    budget = 1;
    @(negedge clk);
    chk("t3_no_valid", ifc.instr_valid, 0);
    drain("t3_drain");

    // redirect to unaligned 0x203 while decode accepts
    @(posedge clk); #1;
    ifc.instr_ready = 1'b0;
    exp_addr.push_back(32'h104);
    budget = 1;
    wait_valid("t4_valid");
    @(posedge clk); #1;
    exp_pc.push_back(32'h104);
    exp_pc.push_back(32'h200);
    exp_addr.push_back(32'h200);
    budget = 1;
    ifc.instr_ready = 1'b1;
    pulse_redirect(32'h203);
    drain("t4_drain");

    // two redirects during flush: one squashed ack, last target wins
    @(posedge clk); #1;
    exp_addr.push_back(32'h204);
    dead_mode = 1'b1;
    pulse_redirect(32'h40);
    @(posedge clk); #1;
    pulse_redirect(32'h80);
    @(negedge clk);
    chk("t5_flush_req",  ifc.imem_req,  1);
    chk("t5_flush_addr", ifc.imem_addr, 32'h204);
    @(posedge clk); #1;
    budget = 1;
    wait_budget("t5_squash_ack");
    @(posedge clk); #1;
    dead_mode = 1'b0;
    exp_addr.push_back(32'h80);
    exp_pc.push_back(32'h80);
    budget = 1;
    drain("t5_drain");

    // PC wrap at the top of the address space
    @(posedge clk); #1;
    exp_addr.push_back(32'h84);
    dead_mode = 1'b1;
    pulse_redirect(32'hFFFF_FFFC);
    budget = 1;
    wait_budget("t6_squash_ack");
    @(posedge clk); #1;
    dead_mode = 1'b0;
    exp_addr.push_back(32'hFFFF_FFFC);
    exp_addr.push_back(32'h0);
    exp_pc.push_back(32'hFFFF_FFFC);
    exp_pc.push_back(32'h0);
    budget = 2;
    drain("t6_drain");
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_next_req",  ifc.imem_req,  1);
    chk("t6_next_addr", ifc.imem_addr, 32'h4);

`ifdef FETCH_TIMEOUT_EN
    chk("to_err_pre", fetch_err, 0);
    for (int i = 0; i < 40 && !fetch_err; i++) @(negedge clk);
    @(negedge clk);
    chk("to_err",    fetch_err, 1);
    chk("to_cycles", last_run,  8);
    chk("to_req",    ifc.imem_req, 0);
    repeat (3) @(negedge clk);
    chk("to_stay_idle", ifc.imem_req, 0);
    chk("to_sticky",    fetch_err,    1);
`endif

    // reset asserted mid-transaction takes effect at once
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mrst_req",   ifc.imem_req,    0);
    chk("mrst_addr",  ifc.imem_addr,   32'h0);
    chk("mrst_valid", ifc.instr_valid, 0);
    chk("mrst_pcout", ifc.pc_out,      0);
    chk("addr_q_left", exp_addr.size(), 0);
    chk("pc_q_left",   exp_pc.size(),   0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
